adder_64_result_skid: RTL
=========================

ADDER_64_RESULT_SKID -- requirements
Module: adder_64_result_skid

Interface
REQ-001: The block SHALL have no parameters; data width is fixed at 64 bits plus 1 carry bit.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004: in_valid  input  1  upstream 64-bit adder result valid.
REQ-005: in_ready  output  1  block can accept a result this cycle.
REQ-006: in_sum  input  64  sum from the 64-bit adder.
REQ-007: in_cout  input  1  carry-out from the 64-bit adder.
REQ-008: out_valid  output  1  buffered result available downstream.
REQ-009: out_ready  input  1  downstream accepts the result this cycle.
REQ-010: out_sum  output  64  buffered sum (head entry).
REQ-011: out_cout  output  1  buffered carry-out (head entry).
REQ-012: out_zero  output  1  head entry has out_sum == 0 and out_cout == 0.
REQ-013: carry_cnt  output  16  count of accepted results with cout = 1 (present only with CARRY_COUNT_EN).

Function
REQ-014: The block SHALL be a 2-entry skid buffer: head register (drives outputs) and skid register.
REQ-015: The state machine SHALL have states EMPTY, ONE, TWO, encoded in registers.
REQ-016: in_ready SHALL be registered-derived: 1 in EMPTY and ONE, 0 in TWO; it SHALL NOT depend combinationally on out_ready.
REQ-017: out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-018: Push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-019: EMPTY: push -> ONE, head loaded; else stay.
REQ-020: ONE: push & pop -> ONE, head loaded with new input; push only -> TWO, skid loaded; pop only -> EMPTY; neither -> stay.
REQ-021: TWO: pop -> ONE, head loaded from skid; no pop -> stay, all data held.
REQ-022: Latency SHALL be 1 cycle: result pushed at edge N is on out_sum/out_cout after edge N if buffer was EMPTY.
REQ-023: Ordering SHALL be strict FIFO; no result dropped or duplicated under any valid/ready pattern.
REQ-024: While out_valid = 1 and out_ready = 0, out_sum, out_cout, out_zero SHALL hold stable.
REQ-025: out_zero SHALL be combinational from head register; value is don't-care when out_valid = 0.
REQ-026: in_sum/in_cout SHALL be ignored when no push occurs.

Reset
REQ-027: On rst_n = 0, state SHALL go to EMPTY immediately, regardless of clock.
REQ-028: Reset values: out_valid = 0, in_ready = 1 (after state EMPTY), out_sum = 0, out_cout = 0, out_zero = 1, carry_cnt = 0.
REQ-029: Reset mid-transfer SHALL discard both entries; no buffered result appears after deassertion.
REQ-030: First push SHALL be accepted on the first rising edge with rst_n = 1.

Configuration
REQ-031: Macro CARRY_COUNT_EN SHALL control the carry counter.
REQ-032: With CARRY_COUNT_EN defined: carry_cnt increments by 1 on each push with in_cout = 1, wraps 16'hFFFF -> 16'h0000, no saturation.
REQ-033: Without CARRY_COUNT_EN: carry_cnt port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-034: Reset then push in_sum = 64'h0000_0000_0000_0005, in_cout = 0, out_ready = 1 -> next cycle out_valid = 1, out_sum = 5, out_zero = 0, then EMPTY.
REQ-035: out_ready = 0, push 64'hA then 64'hB -> in_ready = 0 after second push; third in_valid held not accepted; release out_ready -> outputs A then B in order.
REQ-036: Continuous in_valid/out_ready = 1 for 100 random results -> one result out per cycle, order and values match, in_ready never drops.
REQ-037: Push sum = 0, cout = 0 -> out_zero = 1; push sum = 0, cout = 1 -> out_zero = 0.
REQ-038: Assert rst_n = 0 asynchronously while in TWO -> out_valid = 0 at once; after release no stale data emitted.
REQ-039: With CARRY_COUNT_EN, preset 65535 carry pushes then one more -> carry_cnt = 16'h0000; without macro build compiles and REQ-034..038 pass.

Source files
------------

// File: rtl/adder_64_result_skid.sv
// adder_64_result_skid: 2-entry skid buffer for a 64-bit adder result (sum + carry); CARRY_COUNT_EN adds carry_cnt
module adder_64_result_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_sum,
    input  logic        in_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_sum,
    output logic        out_cout,
    output logic        out_zero
`ifdef CARRY_COUNT_EN
    ,
    output logic [15:0] carry_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t      state, next_state;
    logic [63:0] skid_sum;
    logic        skid_cout;
    logic        push, pop, load_head_in, load_head_skid, load_skid;
    assign in_ready  = state != TWO;
    assign out_valid = state != EMPTY;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_zero  = out_sum == 64'd0 && !out_cout;
    // Next state and register load enables from the occupancy and handshakes
    always_comb begin
        next_state     = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                next_state   = push ? ONE : EMPTY;
                load_head_in = push;
            end
            ONE: begin
                next_state   = push && !pop ? TWO : !push && pop ? EMPTY : ONE;
                load_head_in = push && pop;
                load_skid    = push && !pop;
            end
            TWO: begin
                next_state     = pop ? ONE : TWO;
                load_head_skid = pop;
            end
            default: next_state = EMPTY;
        endcase
    end
    // Occupancy register; reset empties the buffer immediately
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= EMPTY;
        else        state <= next_state;
    // Head and skid data registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_sum   <= 64'd0;
            out_cout  <= 1'b0;
            skid_sum  <= 64'd0;
            skid_cout <= 1'b0;
        end else begin
            if (load_head_in) begin
                out_sum  <= in_sum;
                out_cout <= in_cout;
            end else if (load_head_skid) begin
                out_sum  <= skid_sum;
                out_cout <= skid_cout;
            end
            if (load_skid) begin
                skid_sum  <= in_sum;
                skid_cout <= in_cout;
            end
        end
`ifdef CARRY_COUNT_EN
    // Counts accepted results carrying out; wraps at 16 bits
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                carry_cnt <= 16'd0;
        else if (push && in_cout)  carry_cnt <= carry_cnt + 16'd1;
`endif
endmodule
